// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response compactor.
//   bist_state_e : controller states (idle, compacting, result held)
//   DefaultPoly* : default MISR feedback taps for common register lengths;
//                  bit i set means the shifted-out MSB is XORed into bit i.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } bist_state_e;

  localparam logic [3:0]  DefaultPoly4  = 4'h3;
  localparam logic [7:0]  DefaultPoly8  = 8'h1D;
  localparam logic [15:0] DefaultPoly16 = 16'h1021;  // x^16 + x^12 + x^5 + 1

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register. Pure datapath with no sequencing of its own.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset (clears the register)
//   load        : load load_value (takes priority over step)
//   load_value  : value written on load
//   step        : perform one compaction step with data
//   data        : WIDTH-bit response, XORed into the low bits
//   sig         : current register contents
//   next_sig    : value the register would take on a step this cycle
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned           WIDTH     = 2,
  parameter int unsigned           SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY      = DefaultPoly16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SIG_WIDTH-1:0] load_value,
  input  logic                 step,
  input  logic [WIDTH-1:0]     data,
  output logic [SIG_WIDTH-1:0] sig,
  output logic [SIG_WIDTH-1:0] next_sig
);

  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] data_ext;

  always_comb begin
    data_ext             = '0;
    data_ext[WIDTH-1:0]  = data;
    // Shift left, fold the outgoing MSB back through the taps, then inject the sample.
    next_sig = {sig_q[SIG_WIDTH-2:0], 1'b0}
             ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
             ^ data_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (load) begin
      sig_q <= load_value;
    end else if (step) begin
      sig_q <= next_sig;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_response_compactor.sv
// Output response analyzer for a circuit under test. After start, compacts CYCLES
// valid response samples into a MISR, then compares the result with a golden value.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : begin a run (honoured when idle or done)
//   clear       : synchronous abort back to idle, clears signature/done/pass
//   resp_valid  : resp_in holds a valid CUT sample this cycle
//   resp_in     : CUT primary outputs
//   expected    : golden signature, compared on the final sample
//   busy        : a run is in progress
//   done        : run finished, result held
//   pass        : with done, signature matched expected
//   signature   : current MISR contents
module bist_response_compactor
  import bist_pkg::*;
#(
  parameter int unsigned           WIDTH     = 2,
  parameter int unsigned           SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY      = DefaultPoly16,
  parameter logic [SIG_WIDTH-1:0]  SEED      = '0,
  parameter int unsigned           CYCLES    = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 resp_valid,
  input  logic [WIDTH-1:0]     resp_in,
  input  logic [SIG_WIDTH-1:0] expected,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int unsigned     CntW    = $clog2(CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CYCLES - 1);

  bist_state_e          state_q;
  logic [CntW-1:0]      count_q;
  logic                 busy_q, done_q, pass_q;

  logic                 start_ok;
  logic                 misr_load;
  logic                 misr_step;
  logic [SIG_WIDTH-1:0] misr_load_value;
  logic [SIG_WIDTH-1:0] next_sig;

  // MISR sequencing mirrors the FSM below: clear wins, start is ignored mid-run.
  always_comb begin
    start_ok        = start && (state_q != StRun);
    misr_load       = clear || start_ok;
    misr_load_value = clear ? '0 : SEED;
    misr_step       = !clear && (state_q == StRun) && resp_valid;
  end

  bist_misr #(
    .WIDTH     (WIDTH),
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY)
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (misr_load),
    .load_value (misr_load_value),
    .step       (misr_step),
    .data       (resp_in),
    .sig        (signature),
    .next_sig   (next_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (clear) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StRun: begin
          if (resp_valid) begin
            count_q <= count_q + CntW'(1);
            if (count_q == LastCnt) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // Compare against the value being written this edge, so the
              // verdict appears together with the final signature.
              pass_q  <= (next_sig == expected);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule
